apb_slv_if_param: RTL and testbench

APB_SLV_IF_PARAM -- requirements
Module: apb_slv_if_param

---
 rtl/apb_slv_if_param.sv | 158 +++++++++++++++
 tb/tb_apb_slv_if_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slv_if_param.sv
`default_nettype none
// ============================================================================
// Module   : apb_slv_if_param
// Brief    : APB slave front-end with programmable wait states that bridges
//            transfers onto a simple register port (address/data/strobe/pulses).
// Revision : 1.0 - initial release
// ============================================================================
module apb_slv_if_param #(
    parameter  int ADDR_W      = 12,
    parameter  int DATA_W      = 32,
    parameter  int WAIT_CYCLES = 0,
    parameter  int ADDR_LIMIT  = 4096,
    localparam int SB_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [SB_W-1:0]   pstrb_i,
    output logic              pready_o,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pslverr_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic [SB_W-1:0]   reg_wstrb_o,
    output logic              reg_wr_o,
    output logic              reg_rd_done_o,
    input  logic [DATA_W-1:0] reg_rdata_i
);

    localparam int c_lsb_w = $clog2(SB_W);
    localparam int c_cnt_w = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int c_cmp_w = (ADDR_W > 32) ? ADDR_W : 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_write;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [SB_W-1:0]     r_wstrb;
    logic                r_pready;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_wr;
    logic                r_rd_done;

    logic                w_setup;
    logic                w_err;
    logic [DATA_W-1:0]   w_rd_val;

    assign w_setup  = psel_i & ~penable_i;
    assign w_err    = (c_cmp_w'(paddr_i) >= c_cmp_w'(ADDR_LIMIT)) | (|paddr_i[c_lsb_w-1:0]);
    assign w_rd_val = (~r_write & ~r_err) ? reg_rdata_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_pready  <= 1'b0;
            r_wr      <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_wr      <= 1'b0;
            r_rd_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_write <= pwrite_i;
                        r_err   <= w_err;
                        r_addr  <= paddr_i;
                        r_wdata <= pwdata_i;
                        r_wstrb <= pwrite_i ? pstrb_i : '0;
                        if (WAIT_CYCLES == 0) begin
                            r_state  <= S_ACCESS;
                            r_pready <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_cnt_w'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_ACCESS;
                        r_pready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACCESS: begin
                    // A dropped psel is an abort: leave without touching the register side
                    if (!psel_i) begin
                        r_state  <= S_IDLE;
                        r_pready <= 1'b0;
                    end else if (penable_i) begin
                        r_state   <= S_IDLE;
                        r_pready  <= 1'b0;
                        r_wr      <= r_write & ~r_err & (|r_wstrb);
                        r_rd_done <= ~r_write & ~r_err;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_pready <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (WAIT_CYCLES > 0) begin : g_wait_states
            // reg_addr_o has been stable through WAIT, so sample on the ACCESS transition
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prdata <= '0;
                end else if (r_state == S_WAIT && r_cnt == '0) begin
                    r_prdata <= w_rd_val;
                end
            end
            assign prdata_o = r_prdata;
        end else begin : g_no_wait
            // Without wait states reg_addr_o only becomes valid in ACCESS itself, so
            // the lookup is presented live there and held once the transfer leaves
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prdata <= '0;
                end else if (r_state == S_ACCESS) begin
                    r_prdata <= w_rd_val;
                end
            end
            assign prdata_o = (r_state == S_ACCESS) ? w_rd_val : r_prdata;
        end
    endgenerate

    assign pready_o      = r_pready;
    assign pslverr_o     = r_pready & r_err;
    assign reg_addr_o    = r_addr;
    assign reg_wdata_o   = r_wdata;
    assign reg_wstrb_o   = r_wstrb;
    assign reg_wr_o      = r_wr;
    assign reg_rd_done_o = r_rd_done;

endmodule
`default_nettype wire

// File: tb/tb_apb_slv_if_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slv_if_param
// Brief    : Bench for apb_slv_if_param with three instances (0, 3 and 5 wait
//            states) sharing one APB stimulus bus, psel steered to one at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slv_if_param;

    typedef struct {
        int          sel;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          err;
        bit          wr_p;
        bit          rd_p;
        logic [31:0] prdata;
        bit          chain;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel;

    logic        psel_a    [3];
    logic        pready_a  [3];
    logic        pslverr_a [3];
    logic        wr_a      [3];
    logic        rd_a      [3];
    logic [31:0] prdata_a  [3];
    logic [31:0] rwdata_a  [3];
    logic [31:0] rdata_a   [3];
    logic [15:0] raddr_a   [3];
    logic [3:0]  wstrb_a   [3];

    int n_chk;
    int n_fail;

    function automatic logic [31:0] rmodel(input logic [15:0] a);
        return (a == 16'h0004) ? 32'h12345678 : {16'hA5C3, a};
    endfunction

    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            assign psel_a[k]  = psel && (sel == k);
            assign rdata_a[k] = rmodel(raddr_a[k]);
            apb_slv_if_param #(
                .ADDR_W      (16),
                .DATA_W      (32),
                .WAIT_CYCLES ((k == 0) ? 0 : ((k == 1) ? 3 : 5)),
                .ADDR_LIMIT  ((k == 1) ? 32'h800 : 4096)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .psel_i        (psel_a[k]),
                .penable_i     (penable),
                .pwrite_i      (pwrite),
                .paddr_i       (paddr),
                .pwdata_i      (pwdata),
                .pstrb_i       (pstrb),
                .pready_o      (pready_a[k]),
                .prdata_o      (prdata_a[k]),
                .pslverr_o     (pslverr_a[k]),
                .reg_addr_o    (raddr_a[k]),
                .reg_wdata_o   (rwdata_a[k]),
                .reg_wstrb_o   (wstrb_a[k]),
                .reg_wr_o      (wr_a[k]),
                .reg_rd_done_o (rd_a[k]),
                .reg_rdata_i   (rdata_a[k])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input int k, input string p);
        chk({p, "_pready"},  32'(pready_a[k]),  32'h0);
        chk({p, "_pslverr"}, 32'(pslverr_a[k]), 32'h0);
        chk({p, "_prdata"},  prdata_a[k],       32'h0);
        chk({p, "_raddr"},   32'(raddr_a[k]),   32'h0);
        chk({p, "_rwdata"},  rwdata_a[k],       32'h0);
        chk({p, "_wstrb"},   32'(wstrb_a[k]),   32'h0);
        chk({p, "_wr"},      32'(wr_a[k]),      32'h0);
        chk({p, "_rd"},      32'(rd_a[k]),      32'h0);
    endtask

    task automatic drive_setup(input vec_t v);
        sel     = v.sel;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = v.wr;
        paddr   = v.addr;
        pwdata  = v.wdata;
        pstrb   = v.strb;
    endtask

    // Entered at the negedge of the setup cycle; leaves after checking the pulse cycle
    task automatic xfer(input int idx, input vec_t v, input vec_t nxt);
        int    n;
        int    k;
        int    lat;
        string p;
        k   = v.sel;
        p   = $sformatf("v%0d", idx);
        lat = (k == 0) ? 2 : ((k == 1) ? 5 : 7);
        chk({p, "_setup_pready"}, 32'(pready_a[k]), 32'h0);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 2;
        @(negedge clk);
        while (!pready_a[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        chk({p, "_latency"}, 32'(n), 32'(lat));
        chk({p, "_pslverr"}, 32'(pslverr_a[k]), 32'(v.err));
        chk({p, "_prdata"},  prdata_a[k], v.prdata);
        @(posedge clk); #1;
        if (v.chain) begin
            drive_setup(nxt);
        end else begin
            psel    = 1'b0;
            penable = 1'b0;
        end
        @(negedge clk);
        chk({p, "_done_pready"}, 32'(pready_a[k]), 32'h0);
        chk({p, "_reg_wr"},      32'(wr_a[k]),     32'(v.wr_p));
        chk({p, "_reg_rd_done"}, 32'(rd_a[k]),     32'(v.rd_p));
        chk({p, "_reg_addr"},    32'(raddr_a[k]),  32'(v.addr));
        chk({p, "_reg_wstrb"},   32'(wstrb_a[k]),  v.wr ? 32'(v.strb) : 32'h0);
        if (v.wr) chk({p, "_reg_wdata"}, rwdata_a[k], v.wdata);
        if (!v.chain) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({p, "_pulse_width"}, 32'({wr_a[k], rd_a[k]}), 32'h0);
        end
    endtask

    vec_t vecs [15];
    vec_t post;

    initial begin
        bit quiet;
        n_chk   = 0;
        n_fail  = 0;
        sel     = 0;
        rst     = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;

        //            sel wr addr       wdata         strb err wr rd prdata        chain
        vecs[0]  = '{0, 1, 16'h0100, 32'hDEADBEEF, 4'hF, 0, 1, 0, 32'h00000000, 0};
        vecs[1]  = '{0, 0, 16'h0004, 32'h00000000, 4'h0, 0, 0, 1, 32'h12345678, 0};
        vecs[2]  = '{0, 0, 16'h0200, 32'h00000000, 4'h0, 0, 0, 1, 32'hA5C30200, 0};
        vecs[3]  = '{0, 0, 16'h0FFE, 32'h00000000, 4'h0, 1, 0, 0, 32'h00000000, 0};
        vecs[4]  = '{0, 0, 16'h0FFC, 32'h00000000, 4'h0, 0, 0, 1, 32'hA5C30FFC, 0};
        vecs[5]  = '{0, 0, 16'h1000, 32'h00000000, 4'h0, 1, 0, 0, 32'h00000000, 0};
        vecs[6]  = '{0, 1, 16'h0010, 32'h11112222, 4'h3, 0, 1, 0, 32'h00000000, 1};
        vecs[7]  = '{0, 1, 16'h0014, 32'h33334444, 4'h0, 0, 0, 0, 32'h00000000, 0};
        vecs[8]  = '{1, 0, 16'h0004, 32'h00000000, 4'h0, 0, 0, 1, 32'h12345678, 0};
        vecs[9]  = '{1, 1, 16'h1002, 32'hCAFEF00D, 4'hF, 1, 0, 0, 32'h00000000, 0};
        vecs[10] = '{1, 0, 16'h07FC, 32'h00000000, 4'h0, 0, 0, 1, 32'hA5C307FC, 1};
        vecs[11] = '{1, 0, 16'h0FFC, 32'h00000000, 4'h0, 1, 0, 0, 32'h00000000, 0};
        vecs[12] = '{1, 0, 16'h0800, 32'h00000000, 4'h0, 1, 0, 0, 32'h00000000, 0};
        vecs[13] = '{2, 1, 16'h0020, 32'h0BADF00D, 4'h5, 0, 1, 0, 32'h00000000, 0};
        vecs[14] = '{2, 0, 16'h0024, 32'h00000000, 4'h0, 0, 0, 1, 32'hA5C30024, 0};
        post     = '{2, 0, 16'h0004, 32'h00000000, 4'h0, 0, 0, 1, 32'h12345678, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("reset%0d", k));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (i == 0 || !vecs[i-1].chain) begin
                @(posedge clk); #1;
                drive_setup(vecs[i]);
                @(negedge clk);
            end
            xfer(i, vecs[i], (i < 14) ? vecs[i+1] : vecs[i]);
        end

        // Aborted transfer: psel drops while the 0-wait instance sits in ACCESS
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'h0040; pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge clk); #1;
        psel = 1'b0;
        @(negedge clk);
        chk("abort_in_access", 32'(pready_a[0]), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pready", 32'(pready_a[0]), 32'h0);
        chk("abort_pulse1", 32'({wr_a[0], rd_a[0]}), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pulse2", 32'({wr_a[0], rd_a[0]}), 32'h0);

        // psel with penable but no preceding setup is not a transfer
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 16'h0100; pstrb = 4'hF;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (pready_a[0] || wr_a[0] || rd_a[0]) quiet = 1'b0;
        end
        chk("no_setup_ignored", 32'(quiet), 32'h1);
        #1;
        psel = 1'b0; penable = 1'b0;

        // Reset while the 5-wait instance is counting down a read
        @(posedge clk); #1;
        drive_setup(post);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_zero(2, "midrst");
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (pready_a[2] || rd_a[2] || wr_a[2]) quiet = 1'b0;
        end
        chk("midrst_no_pulse", 32'(quiet), 32'h1);
        @(posedge clk); #1;
        drive_setup(post);
        @(negedge clk);
        xfer(99, post, post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
